// File: rtl/riscv_pkg.sv
// Shared opcode constants, FSM state and trap-cause encodings for the RV32I sequencer.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } ctrl_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_ILLEGAL  = 2'd1,
        CAUSE_FETCH_TO = 2'd2,
        CAUSE_MEM_TO   = 2'd3
    } trap_cause_t;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/riscv_ctrl_watchdog.sv
// Request watchdog: counts consecutive request cycles without acknowledge and flags
// the TIMEOUT-th such cycle so the sequencer can trap instead of advancing.
module riscv_ctrl_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 8'd1;
        end
    end

    // count_en already means "no acknowledge this cycle", so a late ack still wins
    assign expired = count_en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/riscv_core_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the RV32I core.
// Optional perf counters (cycle_count, instret_count) under RISCV_CORE_CTRL_PERF_EN.
//
// state  | meaning
// IDLE   | after reset, leaves on the next clock
// FETCH  | insn_req high, waits for insn_ack (ir_load same cycle)
// DECODE | opcode legality check
// EXEC   | latch taken / store / rd-write flags, pick MEM or WB
// MEM    | mem_req high, waits for mem_ack
// WB     | rd write strobe and pc_load, back to FETCH
// TRAP   | terminal until reset, trap and trap_cause held
module riscv_core_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic              insn_req,
    input  logic              insn_ack,
    input  logic [6:0]        opcode,
    input  logic              branch_taken,
    output logic              ir_load,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              rd_enable_write,
    output logic              pc_load,
    output logic              pc_sel,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [2:0]        state
`ifdef RISCV_CORE_CTRL_PERF_EN
    ,
    output logic [2*XLEN-1:0] cycle_count,
    output logic [2*XLEN-1:0] instret_count
`endif
);

    if (TIMEOUT < 2 || TIMEOUT > 255 || XLEN < 1) begin : g_bad_param
        $error("riscv_core_ctrl: TIMEOUT must be 2..255 and XLEN positive");
    end

    ctrl_state_t state_q, state_d;
    trap_cause_t cause_q, cause_d;
    logic        taken_q;
    logic        store_q;
    logic        rd_we_q;
    logic        wdog_clear;
    logic        wdog_count_en;
    logic        wdog_expired;

    assign wdog_clear    = (state_q != ST_FETCH) && (state_q != ST_MEM);
    assign wdog_count_en = ((state_q == ST_FETCH) && !insn_ack) ||
                           ((state_q == ST_MEM) && !mem_ack);

    riscv_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (wdog_clear),
        .count_en (wdog_count_en),
        .expired  (wdog_expired)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (insn_ack) begin
                    state_d = ST_DECODE;
                end else if (wdog_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_FETCH_TO;
                end
            end
            ST_DECODE: begin
                if (is_legal_opcode(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d = ST_WB;
                end else if (wdog_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TO;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Opcode is only guaranteed through EXEC, so MEM/WB work from these latched flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taken_q <= 1'b0;
            store_q <= 1'b0;
            rd_we_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            taken_q <= ((opcode == OPC_BRANCH) && branch_taken) ||
                       (opcode == OPC_JAL) || (opcode == OPC_JALR);
            store_q <= (opcode == OPC_STORE);
            rd_we_q <= !((opcode == OPC_BRANCH) || (opcode == OPC_STORE));
        end
    end

    assign insn_req        = (state_q == ST_FETCH);
    assign ir_load         = (state_q == ST_FETCH) && insn_ack;
    assign mem_req         = (state_q == ST_MEM);
    assign mem_we          = (state_q == ST_MEM) && store_q;
    assign rd_enable_write = (state_q == ST_WB) && rd_we_q;
    assign pc_load         = (state_q == ST_WB);
    assign pc_sel          = (state_q == ST_WB) && taken_q;
    assign trap            = (state_q == ST_TRAP);
    assign trap_cause      = cause_q;
    assign state           = state_q;

`ifdef RISCV_CORE_CTRL_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (state_q != ST_IDLE && state_q != ST_TRAP) begin
                cycle_count <= cycle_count + (2*XLEN)'(1);
            end
            if (state_q == ST_WB) begin
                instret_count <= instret_count + (2*XLEN)'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_core_ctrl.sv
// Bench for riscv_core_ctrl: builds an expected per-cycle trace from instruction-level
// rules and compares every cycle, plus hand-computed cycle counts for key scenarios.
module tb_riscv_core_ctrl;

    localparam int TO = 16;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] BAD    = 7'b1111111;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       insn_ack = 1'b0;
    logic       mem_ack = 1'b0;
    logic       branch_taken = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       insn_req, ir_load, mem_req, mem_we, rd_enable_write, pc_load, pc_sel, trap;
    logic [1:0] trap_cause;
    logic [2:0] state;
`ifdef RISCV_CORE_CTRL_PERF_EN
    logic [63:0] cycle_count, instret_count;
`endif

    riscv_core_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clock           (clock),
        .reset           (reset),
        .insn_req        (insn_req),
        .insn_ack        (insn_ack),
        .opcode          (opcode),
        .branch_taken    (branch_taken),
        .ir_load         (ir_load),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_ack         (mem_ack),
        .rd_enable_write (rd_enable_write),
        .pc_load         (pc_load),
        .pc_sel          (pc_sel),
        .trap            (trap),
        .trap_cause      (trap_cause),
        .state           (state)
`ifdef RISCV_CORE_CTRL_PERF_EN
        ,
        .cycle_count     (cycle_count),
        .instret_count   (instret_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        ia;
        logic        ma;
        logic        bt;
        logic [6:0]  opc;
        logic [12:0] exp;
    } cyc_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int   o_cycles, o_first_irl, o_first_pcl, o_ireq, o_mreq, o_mwe, o_rdwe, o_pcl, o_pcsel, o_trap;
    int   o_last_cause;

    // {state, insn_req, ir_load, mem_req, mem_we, rd_we, pc_load, pc_sel, trap, trap_cause}
    function automatic logic [12:0] ev(input logic [2:0] st, input logic ireq, input logic irl,
                                       input logic mreq, input logic mwe, input logic rdwe,
                                       input logic pcl, input logic pcs, input logic tr,
                                       input logic [1:0] c);
        return {st, ireq, irl, mreq, mwe, rdwe, pcl, pcs, tr, c};
    endfunction

    function automatic logic [12:0] outs();
        return {state, insn_req, ir_load, mem_req, mem_we, rd_enable_write, pc_load, pc_sel,
                trap, trap_cause};
    endfunction

    function automatic cyc_t mk(input logic ia, input logic ma, input logic bt,
                                input logic [6:0] opc, input logic [12:0] e);
        cyc_t c;
        c.ia = ia; c.ma = ma; c.bt = bt; c.opc = opc; c.exp = e;
        return c;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_trap(input logic [1:0] cause, input int n);
        for (int i = 0; i < n; i++)
            q.push_back(mk(1'b1, 1'b1, 1'b1, BAD, ev(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 1, cause)));
    endtask

    // One instruction: fwait/mwait = wait cycles before ack (>= TO means never acked)
    task automatic add_insn(input logic [6:0] opc, input int fwait, input int mwait,
                            input logic bt, input logic noise);
        logic a, is_mem, is_store, legal, taken, rdwe;
        int   nf, nm;
        is_store = (opc == STORE);
        is_mem   = (opc == LOAD) || is_store;
        legal    = opc inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP};
        taken    = ((opc == BRANCH) && bt) || (opc == JAL) || (opc == JALR);
        rdwe     = !((opc == BRANCH) || is_store);
        nf = (fwait >= TO) ? TO : fwait + 1;
        for (int i = 0; i < nf; i++) begin
            a = (i == fwait);
            q.push_back(mk(a, noise, 1'b0, opc, ev(S_FETCH, 1, a, 0, 0, 0, 0, 0, 0, 2'd0)));
        end
        if (fwait >= TO) begin
            add_trap(2'd2, 20);
            return;
        end
        q.push_back(mk(noise, noise, ~bt, opc, ev(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0)));
        if (!legal) begin
            add_trap(2'd1, 20);
            return;
        end
        q.push_back(mk(noise, noise, bt, opc, ev(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0)));
        if (is_mem) begin
            nm = (mwait >= TO) ? TO : mwait + 1;
            for (int i = 0; i < nm; i++) begin
                a = (i == mwait);
                q.push_back(mk(noise, a, ~bt, opc,
                               ev(S_MEM, 0, 0, 1, is_store, 0, 0, 0, 0, 2'd0)));
            end
            if (mwait >= TO) begin
                add_trap(2'd3, 20);
                return;
            end
        end
        // opcode deliberately corrupted in WB: the controller must use what it latched
        q.push_back(mk(noise, noise, ~bt, ~opc, ev(S_WB, 0, 0, 0, 0, rdwe, 1, taken, 0, 2'd0)));
    endtask

    task automatic run_n(input int n);
        cyc_t        c;
        logic [12:0] act;
        int          k;
        k = 0;
        o_cycles = 0; o_first_irl = 0; o_first_pcl = 0; o_ireq = 0; o_mreq = 0; o_mwe = 0;
        o_rdwe = 0; o_pcl = 0; o_pcsel = 0; o_trap = 0; o_last_cause = 0;
        while (q.size() > 0 && k < n) begin
            c = q.pop_front();
            @(posedge clock);
            #1;
            insn_ack = c.ia; mem_ack = c.ma; branch_taken = c.bt; opcode = c.opc;
            @(negedge clock);
            k++;
            act = outs();
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL trace step %0d: got %b expected %b", k, act, c.exp);
            end
            if (ir_load && o_first_irl == 0) o_first_irl = k;
            if (pc_load && o_first_pcl == 0) o_first_pcl = k;
            o_ireq  += int'(insn_req);
            o_mreq  += int'(mem_req);
            o_mwe   += int'(mem_we);
            o_rdwe  += int'(rd_enable_write);
            o_pcl   += int'(pc_load);
            o_pcsel += int'(pc_sel);
            o_trap  += int'(trap);
            o_last_cause = int'(trap_cause);
        end
        o_cycles = k;
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        insn_ack = 1'b0; mem_ack = 1'b0;
        #1;
        chk("reset_async_clear", outs(), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("idle_after_reset", outs(), 0);
    endtask

    initial begin
        insn_ack = 1'b1; mem_ack = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_outputs", outs(), 0);
        reset = 1'b0;
        insn_ack = 1'b0; mem_ack = 1'b0;
        #1;
        chk("idle_after_release", outs(), 0);

        // ALU with insn_ack held high
        add_insn(OP, 0, 0, 1'b0, 1'b1);
        chk("model_alu_len", q.size(), 4);
        run_all();
        chk("alu_ir_load_cycle", o_first_irl, 1);
        chk("alu_pc_load_cycle", o_first_pcl, 4);
        chk("alu_pc_sel", o_pcsel, 0);
        chk("alu_rd_we", o_rdwe, 1);

        // LOAD, mem_ack after 3 wait cycles
        add_insn(LOAD, 0, 3, 1'b0, 1'b0);
        chk("model_load_len", q.size(), 8);
        run_all();
        chk("load_fetch_again", o_first_irl, 1);
        chk("load_cycles", o_cycles, 8);
        chk("load_mem_req_cycles", o_mreq, 4);
        chk("load_mem_we_cycles", o_mwe, 0);
        chk("load_rd_we", o_rdwe, 1);

        add_insn(BRANCH, 0, 0, 1'b1, 1'b0);
        run_all();
        chk("branch_taken_pc_sel", o_pcsel, 1);
        chk("branch_taken_rd_we", o_rdwe, 0);
        add_insn(BRANCH, 1, 0, 1'b0, 1'b1);
        run_all();
        chk("branch_not_taken_pc_sel", o_pcsel, 0);
        chk("branch_not_taken_pc_load", o_pcl, 1);

        add_insn(STORE, 2, 1, 1'b0, 1'b1);
        run_all();
        chk("store_cycles", o_cycles, 8);
        chk("store_mem_we_cycles", o_mwe, 2);
        chk("store_rd_we", o_rdwe, 0);

        add_insn(JAL, 0, 0, 1'b0, 1'b0);
        add_insn(JALR, 3, 0, 1'b0, 1'b1);
        add_insn(LUI, 0, 0, 1'b1, 1'b0);
        add_insn(AUIPC, 1, 0, 1'b1, 1'b1);
        run_all();
        chk("jumps_alu_pc_sel", o_pcsel, 2);
        chk("jumps_alu_rd_we", o_rdwe, 4);

        // acknowledges arriving in the TIMEOUT-th request cycle are accepted
        add_insn(OP_IMM, TO - 1, 0, 1'b0, 1'b0);
        run_all();
        chk("late_fetch_ir_load_cycle", o_first_irl, 16);
        chk("late_fetch_no_trap", o_trap, 0);
        add_insn(STORE, 0, TO - 1, 1'b0, 1'b0);
        run_all();
        chk("late_mem_req_cycles", o_mreq, 16);
        chk("late_mem_no_trap", o_trap, 0);

        add_insn(BAD, 0, 0, 1'b0, 1'b1);
        run_all();
        chk("illegal_trap_cycles", o_trap, 20);
        chk("illegal_cause", o_last_cause, 1);
        chk("illegal_no_pc_load", o_pcl, 0);
        chk("illegal_no_rd_we", o_rdwe, 0);
        do_reset();

        add_insn(OP, TO, 0, 1'b0, 1'b0);
        run_all();
        chk("fetch_to_req_cycles", o_ireq, 16);
        chk("fetch_to_cause", o_last_cause, 2);
        do_reset();

        add_insn(LOAD, 0, 99, 1'b0, 1'b1);
        run_all();
        chk("mem_to_req_cycles", o_mreq, 16);
        chk("mem_to_cause", o_last_cause, 3);
        do_reset();

        // reset pulsed in the middle of a stalled MEM phase
        add_insn(LOAD, 0, 10, 1'b0, 1'b0);
        run_n(6);
        q.delete();
        @(posedge clock);
        #1;
        chk("mid_mem_req_before_reset", int'(mem_req), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_mem_req_dropped", int'(mem_req), 0);
        chk("mid_mem_state_idle", int'(state), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("mid_mem_no_strobes", {pc_load, rd_enable_write, mem_req}, 0);
        end
`ifdef RISCV_CORE_CTRL_PERF_EN
        chk("perf_cycle_count_reset", cycle_count, 0);
        chk("perf_instret_count_reset", instret_count, 0);
`endif
        reset = 1'b0;
        #1;
        chk("mid_mem_idle_after_release", outs(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_core_ctrl.md
# riscv_core_ctrl

Multi-cycle sequencing controller for the single-issue RV32I core. It drives the fetch → decode → execute → memory → write-back sequence, the instruction and data memory request/acknowledge handshakes, the register-file write enable and the program-counter load strobe. It sits beside the fetch, decode, register-file and execute blocks inside the core top level, and replaces their currently hard-wired enables.

## Interface
- XLEN, 32: datapath width; sets perf counter width only under the macro.
- TIMEOUT, 16: maximum consecutive request cycles without acknowledge before a trap; legal range 2..255.

- clock  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- insn_req  out  1  instruction fetch request; held until acknowledged.
- insn_ack  in  1  instruction data valid on insn_data_bus this cycle.
- opcode  in  7  opcode field from decode, valid in DECODE and later states.
- branch_taken  in  1  branch compare result from exec; sampled in EXEC.
- ir_load  out  1  one-cycle strobe latching the instruction register.
- mem_req  out  1  data memory request; held until acknowledged.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_ack  in  1  data memory transfer complete.
- rd_enable_write  out  1  register-file write strobe, one cycle.
- pc_load  out  1  PC update strobe, one cycle.
- pc_sel  out  1  0 = PC+4, 1 = branch/jump target; valid with pc_load.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 memory timeout.
- state  out  3  current FSM state, for debug.

## Operation
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: entered on reset; moves to FETCH on the first clock after reset is released.
- FETCH: insn_req=1. On insn_ack, ir_load=1 in the same cycle and the FSM moves to DECODE.
- DECODE: single cycle.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011.
  - Any other opcode moves to TRAP with cause 1.
- EXEC: single cycle.
  - Latches a taken flag: branch_taken for BRANCH, 1 for JAL and JALR, 0 otherwise.
  - LOAD and STORE go to MEM; all other opcodes go to WB.
- MEM: mem_req=1; mem_we=1 for STORE. On mem_ack, moves to WB.
- WB: single cycle.
  - pc_load=1 and pc_sel = latched taken flag.
  - rd_enable_write=1 except for BRANCH and STORE.
  - Next state is FETCH.
- Timeout:
  - The counter clears on entry to FETCH and to MEM, and increments on each request cycle without acknowledge.
  - If TIMEOUT consecutive request cycles pass without acknowledge, the FSM moves to TRAP with cause 2 (FETCH) or 3 (MEM).
  - An acknowledge arriving in the TIMEOUT-th cycle is accepted, not trapped.
- TRAP: terminal. All requests and strobes are 0; trap=1 and trap_cause are held until reset.
- Acknowledges received while the matching request is low are ignored.

## Timing
- Reset values: state=IDLE; all outputs 0; trap_cause=0; taken flag and timeout counter 0.
- The only combinational input-to-output path is insn_ack → ir_load. All other outputs depend on registered state only.
- Latency with zero-wait acknowledge, measured from the first FETCH cycle:
  - ALU, LUI, AUIPC, branch, jump: 4 cycles.
  - LOAD, STORE: 5 cycles.
- Each wait cycle on an acknowledge adds one cycle.
- Reset asserted mid-operation: immediate return to IDLE with requests dropped the same cycle. No write or PC strobe may follow.

## Configuration
- RISCV_CORE_CTRL_PERF_EN defined: adds two outputs, cycle_count and instret_count, each 2*XLEN bits wide, reset to 0.
  - cycle_count increments every cycle in which state ≠ IDLE and state ≠ TRAP.
  - instret_count increments in every WB cycle.
  - Both wrap silently at 2^(2*XLEN).
- Undefined: neither port nor any counter logic exists.

## Structure
- riscv_pkg holds:
  - the opcode localparams;
  - the ctrl_state_t enum (3-bit, values in the listed order from 0);
  - the trap_cause_t enum.
- One sub-module, riscv_ctrl_watchdog: the timeout counter, with clear, count-enable and expired ports, parameterised by TIMEOUT.

## Test plan
- Reset released, opcode 0110011, insn_ack held 1: ir_load on cycle 1; rd_enable_write=1, pc_load=1 and pc_sel=0 on cycle 4; FETCH again on cycle 5.
- LOAD 0000011, mem_ack delayed 3 cycles: mem_req high exactly 4 cycles with mem_we=0; WB writes rd; total 8 cycles.
- BRANCH 1100011 with branch_taken=1 in EXEC: WB gives pc_sel=1, rd_enable_write=0. Repeat with branch_taken=0: pc_sel=0.
- Opcode 1111111: TRAP after DECODE with trap_cause=1; no pc_load and no rd_enable_write; state stays TRAP for 20 cycles.
- insn_ack held 0 with TIMEOUT=16: trap_cause=2 after 16 FETCH cycles. Rerun with ack in cycle 16: no trap.
- Reset pulsed during MEM with mem_req=1: mem_req=0 immediately; state=IDLE; no WB strobe. With the perf macro defined, both counters read 0.
